// File: rtl/io_access_unit.sv
// io_access_unit: single-outstanding load/store engine between pipeline and IO bus.
// Optional bus watchdog enabled by defining IO_ACCESS_UNIT_TIMEOUT_EN.
module io_access_unit #(
    parameter int ADDR_W  = 40,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clean,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        func,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic              bus_valid,
    output logic              bus_rw,
    output logic [1:0]        bus_width,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    input  logic              bus_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              sx_q;
    logic              misaligned;
    logic [DATA_W-1:0] load_ext;
    logic              sign_bit;
    int                top;

`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
    logic [15:0]       tmo_cnt;
`endif

    assign ready = (state == IDLE);

    // Alignment check of the incoming request against its access size.
    always_comb begin
        misaligned = 1'b0;
        case (func[1:0])
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = (|addr[2:0]) || (DATA_W == 32);
        endcase
    end

    // Truncate bus read data to the latched size, then sign/zero extend.
    always_comb begin
        case (bus_width)
            2'd0:    top = 7;
            2'd1:    top = 15;
            2'd2:    top = 31;
            default: top = DATA_W - 1;
        endcase
        sign_bit = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == top) sign_bit = bus_rdata[i];
        end
        load_ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i <= top) ? bus_rdata[i] : (sx_q & sign_bit);
        end
    end

    // Access FSM with all outputs and the latched request registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            error     <= 1'b0;
            bus_valid <= 1'b0;
            bus_rw    <= 1'b0;
            bus_width <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            sx_q      <= 1'b0;
            rdata     <= '0;
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !clean) begin
                        bus_addr  <= addr;
                        bus_rw    <= func[3];
                        bus_width <= func[1:0];
                        sx_q      <= func[2];
                        bus_wdata <= func[3] ? wdata : '0;
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        if (misaligned) begin
                            state <= RESP;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state     <= BUSY;
                            bus_valid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    if (clean) begin
                        state     <= IDLE;
                        bus_valid <= 1'b0;
                    end else if (bus_error) begin
                        state     <= RESP;
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                    end else if (bus_ready) begin
                        state     <= RESP;
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        if (!bus_rw) rdata <= load_ext;
                    end
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
                    else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                        state     <= RESP;
                        bus_valid <= 1'b0;
                        done      <= 1'b1;
                        error     <= 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_access_unit.sv
// tb_io_access_unit: directed vectors with a transaction-level reference model.
// Honours IO_ACCESS_UNIT_TIMEOUT_EN to choose the watchdog scenario.
module tb_io_access_unit;

    localparam int AW = 40;
    localparam int DW = 64;
    localparam int TMO = 4;
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    localparam int STALL = 2;
`else
    localparam bit TMO_EN = 1'b0;
    localparam int STALL = 5;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clean = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    func = '0;
    logic [DW-1:0] rdata;
    logic          ready, done, error;
    logic          bus_valid, bus_rw;
    logic [1:0]    bus_width;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ready = 1'b0;
    logic          bus_error = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    io_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .clean(clean), .start(start),
        .addr(addr), .wdata(wdata), .func(func),
        .rdata(rdata), .ready(ready), .done(done), .error(error),
        .bus_valid(bus_valid), .bus_rw(bus_rw), .bus_width(bus_width),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one access record, outcome decided by bus response.
    bit          started = 1'b0;
    int          m_phase;
    bit          m_done, m_err, m_rw, m_sx;
    logic [1:0]  m_width;
    logic [63:0] m_addr, m_wdata, m_rdata;
    int          m_busy_cycles;

    function automatic logic [63:0] ext_model(logic [63:0] v, logic [1:0] sz, logic sx);
        longint unsigned nbytes;
        longint unsigned span;
        longint unsigned t;
        nbytes = longint'(1) << sz;
        if (nbytes == 8) return v;
        span = longint'(1) << (8 * nbytes);
        t = v % span;
        if (sx && t >= span / 2) t = t - span;
        return t;
    endfunction

    function automatic bit misaligned_model(logic [63:0] a, logic [1:0] sz);
        longint unsigned nbytes;
        nbytes = longint'(1) << sz;
        return ((a % nbytes) != 0) || (sz == 2'd3 && DW == 32);
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_phase = 0; m_done = 0; m_err = 0; m_rw = 0; m_sx = 0;
            m_width = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
            m_busy_cycles = 0;
        end else begin
            m_done = 0;
            m_err = 0;
            if (m_phase == 0) begin
                if (start && !clean) begin
                    m_addr = 64'(addr);
                    m_rw = func[3];
                    m_sx = func[2];
                    m_width = func[1:0];
                    m_wdata = func[3] ? wdata : 64'd0;
                    m_busy_cycles = 0;
                    if (misaligned_model(64'(addr), func[1:0])) begin
                        m_phase = 2; m_done = 1; m_err = 1;
                    end else begin
                        m_phase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                m_busy_cycles++;
                if (clean) begin
                    m_phase = 0;
                end else if (bus_error) begin
                    m_phase = 2; m_done = 1; m_err = 1;
                end else if (bus_ready) begin
                    m_phase = 2; m_done = 1;
                    if (!m_rw) m_rdata = ext_model(bus_rdata, m_width, m_sx);
                end else if (TMO_EN && m_busy_cycles >= TMO) begin
                    m_phase = 2; m_done = 1; m_err = 1;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison of all DUT outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("ready", 64'(ready), 64'(m_phase == 0));
            chk("bus_valid", 64'(bus_valid), 64'(m_phase == 1));
            chk("done", 64'(done), 64'(m_done));
            chk("error", 64'(error), 64'(m_err));
            chk("bus_rw", 64'(bus_rw), 64'(m_rw));
            chk("bus_width", 64'(bus_width), 64'(m_width));
            chk("bus_addr", 64'(bus_addr), m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
            chk("rdata", rdata, m_rdata);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req(input logic [3:0] f, input logic [AW-1:0] a, input logic [DW-1:0] d);
        start = 1'b1; func = f; addr = a; wdata = d;
    endtask

    initial begin
        int nvalid;
        bit sawdone;
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(bus_valid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        rst = 1'b0;

        // signed byte read, best-case latency
        req(4'b0100, 40'h10, 64'hDEAD);
        tick();
        start = 1'b0;
        chk("s1_valid", 64'(bus_valid), 64'd1);
        bus_ready = 1'b1; bus_rdata = 64'h80;
        tick();
        bus_ready = 1'b0;
        chk("s1_done", 64'(done), 64'd1);
        chk("s1_err", 64'(error), 64'd0);
        chk("s1_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
        tick();
        chk("s1_ready", 64'(ready), 64'd1);

        // misaligned halfword write
        req(4'b1001, 40'h3, 64'h1234);
        tick();
        start = 1'b0;
        chk("s2_valid", 64'(bus_valid), 64'd0);
        chk("s2_done", 64'(done), 64'd1);
        chk("s2_err", 64'(error), 64'd1);
        chk("s2_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);
        tick();

        // start with clean ignored
        req(4'b0011, 40'h8, 64'h0);
        clean = 1'b1;
        tick();
        start = 1'b0; clean = 1'b0;
        chk("s3_ignored", 64'(ready), 64'd1);

        // stalled word read, start during BUSY ignored
        req(4'b0010, 40'h100, 64'h0);
        tick();
        req(4'b0000, 40'h777, 64'h0);
        bus_rdata = 64'hFFFF;
        for (int i = 0; i < STALL; i++) begin
            chk("s4_addr", 64'(bus_addr), 64'h100);
            chk("s4_valid", 64'(bus_valid), 64'd1);
            tick();
        end
        start = 1'b0;
        chk("s4_addr_last", 64'(bus_addr), 64'h100);
        bus_ready = 1'b1; bus_rdata = 64'h1_8000_0000;
        tick();
        bus_ready = 1'b0;
        chk("s4_done", 64'(done), 64'd1);
        chk("s4_rdata", rdata, 64'h8000_0000);
        tick();

        // aligned write leaves rdata alone
        req(4'b1011, 40'h20, 64'hCAFE_F00D_1234_5678);
        tick();
        start = 1'b0;
        chk("s5_rw", 64'(bus_rw), 64'd1);
        chk("s5_wdata", bus_wdata, 64'hCAFE_F00D_1234_5678);
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        chk("s5_rdata", rdata, 64'h8000_0000);
        tick();

        // clean two cycles into BUSY, then a normal access
        req(4'b0011, 40'h8, 64'h0);
        tick();
        start = 1'b0;
        tick();
        clean = 1'b1;
        tick();
        clean = 1'b0;
        chk("s6_valid", 64'(bus_valid), 64'd0);
        chk("s6_ready", 64'(ready), 64'd1);
        chk("s6_done", 64'(done), 64'd0);
        req(4'b0011, 40'h18, 64'h0);
        tick();
        start = 1'b0;
        bus_ready = 1'b1; bus_rdata = 64'h1122_3344_5566_7788;
        tick();
        bus_ready = 1'b0;
        chk("s6_done2", 64'(done), 64'd1);
        chk("s6_rdata", rdata, 64'h1122_3344_5566_7788);
        tick();

        // signed halfword, positive value
        req(4'b0101, 40'h2, 64'h0);
        tick();
        start = 1'b0;
        bus_ready = 1'b1; bus_rdata = 64'hABCD_7FFF;
        tick();
        bus_ready = 1'b0;
        chk("s7_rdata", rdata, 64'h7FFF);
        tick();

        // bus_error wins over bus_ready
        req(4'b0010, 40'h4, 64'h0);
        tick();
        start = 1'b0;
        bus_ready = 1'b1; bus_error = 1'b1; bus_rdata = 64'h5555;
        tick();
        bus_ready = 1'b0; bus_error = 1'b0;
        chk("s8_err", 64'(error), 64'd1);
        chk("s8_rdata", rdata, 64'h7FFF);
        tick();

        // silent bus
        req(4'b0000, 40'h5, 64'h0);
        tick();
        start = 1'b0;
`ifdef IO_ACCESS_UNIT_TIMEOUT_EN
        nvalid = 0;
        sawdone = 1'b0;
        for (int i = 0; i < 12 && !sawdone; i++) begin
            if (bus_valid) nvalid++;
            if (done) begin
                sawdone = 1'b1;
                chk("s9_err", 64'(error), 64'd1);
            end else begin
                tick();
            end
        end
        chk("s9_done_seen", 64'(sawdone), 64'd1);
        chk("s9_nvalid", 64'(nvalid), 64'd4);
        tick();
`else
        nvalid = 0;
        sawdone = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus_valid) nvalid++;
            if (done) sawdone = 1'b1;
            tick();
        end
        chk("s9_nvalid", 64'(nvalid), 64'd100);
        chk("s9_nodone", 64'(sawdone), 64'd0);
        chk("s9_busy", 64'(bus_valid), 64'd1);
        clean = 1'b1;
        tick();
        clean = 1'b0;
        chk("s9_ready", 64'(ready), 64'd1);
`endif

        // reset mid-BUSY while bus answers
        req(4'b1011, 40'h40, 64'h99);
        tick();
        start = 1'b0;
        bus_ready = 1'b1; bus_error = 1'b1; rst = 1'b1;
        tick();
        bus_ready = 1'b0; bus_error = 1'b0; rst = 1'b0;
        chk("s10_done", 64'(done), 64'd0);
        chk("s10_err", 64'(error), 64'd0);
        chk("s10_ready", 64'(ready), 64'd1);
        chk("s10_valid", 64'(bus_valid), 64'd0);
        chk("s10_rw", 64'(bus_rw), 64'd0);
        chk("s10_addr", 64'(bus_addr), 64'd0);
        chk("s10_wdata", bus_wdata, 64'd0);
        chk("s10_width", 64'(bus_width), 64'd0);
        chk("s10_rdata", rdata, 64'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/io_access_unit.md
IO_ACCESS_UNIT -- requirements
Module: io_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 40, meaning bus address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning data width; only 32 and 64 are legal.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the number of BUSY cycles allowed before abort; legal range 1..65535.
REQ-004 Ports SHALL be:
 clk  in  1  sole clock, rising edge
 rst  in  1  synchronous active-high reset
 clean  in  1  pipeline flush, abort current access
 start  in  1  request strobe
 addr  in  ADDR_W  access address
 wdata  in  DATA_W  store data
 func  in  4  [3]=write, [2]=sign-extend (reads only), [1:0]=log2 size in bytes
 rdata  out  DATA_W  extended load result
 ready  out  1  idle, request may be accepted
 done  out  1  one-cycle completion pulse
 error  out  1  qualifies done: access failed
 bus_valid  out  1  bus request
 bus_rw  out  1  1=write
 bus_width  out  2  copy of latched func[1:0]
 bus_addr  out  ADDR_W  latched address
 bus_wdata  out  DATA_W  latched store data, zero when bus_rw=0
 bus_rdata  in  DATA_W  read data, LSB-aligned
 bus_ready  in  1  bus accepts/completes the access
 bus_error  in  1  bus fault

Function
REQ-005 The FSM SHALL have states IDLE, BUSY, RESP; ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, start=1 with clean=0 SHALL latch addr, wdata, func and move to BUSY, or to RESP with error if misaligned.
REQ-007 An access SHALL be misaligned when addr modulo (1<<func[1:0]) is nonzero, or when func[1:0]=3 with DATA_W=32.
REQ-008 In BUSY, bus_valid SHALL be 1 and bus_* outputs SHALL be stable until exit.
REQ-009 BUSY SHALL move to RESP on bus_ready=1 (error=0) or bus_error=1 (error=1); bus_error SHALL win when both are 1.
REQ-010 RESP SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-011 Best-case latency SHALL be: start at cycle N, bus_valid at N+1, bus_ready at N+1, done at N+2.
REQ-012 A read completion SHALL register rdata = bus_rdata truncated to the access size, then sign-extended if func[2]=1, otherwise zero-extended.
REQ-013 rdata SHALL hold its value until the next successful read completion.
REQ-014 Writes and failed accesses SHALL leave rdata unchanged.
REQ-015 clean=1 in any state SHALL force IDLE next cycle, drop bus_valid, and suppress done for the aborted access.
REQ-016 start=1 while not in IDLE SHALL be ignored.
REQ-017 start=1 together with clean=1 SHALL be ignored.

Reset
REQ-018 rst=1 at a clock edge SHALL enter IDLE and clear all registered state.
REQ-019 After reset: ready=1; done, error, bus_valid, bus_rw=0; rdata, bus_addr, bus_wdata, bus_width, timeout counter=0.
REQ-020 Reset SHALL take priority over clean and start, including mid-access.

Configuration
REQ-021 With IO_ACCESS_UNIT_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-022 With the macro defined, reaching TIMEOUT cycles without bus_ready or bus_error SHALL drop bus_valid and go to RESP with error=1.
REQ-023 Without the macro, no counter logic SHALL exist and BUSY SHALL wait indefinitely.

Verification
REQ-024 The bench SHALL cover: read, func=4'b0100, addr=0x10, bus_rdata=0x80 with bus_ready one cycle after bus_valid -> done at N+2, rdata=0xFFFFFFFFFFFFFF80, error=0.
REQ-025 The bench SHALL cover: write, func=4'b1001, addr=0x3 -> no bus_valid, done+error at N+1, rdata unchanged.
REQ-026 The bench SHALL cover: read, func=4'b0010, bus_ready stalled 5 cycles then bus_rdata=0x1_8000_0000 -> bus_addr stable throughout, rdata=0x80000000.
REQ-027 The bench SHALL cover: clean asserted two cycles into BUSY -> bus_valid=0 next cycle, ready=1, no done; a following start is accepted normally.
REQ-028 The bench SHALL cover: TIMEOUT=4 with the macro, bus silent -> bus_valid for exactly 4 cycles, then done+error; without the macro -> still BUSY after 100 cycles.
REQ-029 The bench SHALL cover: rst pulsed mid-BUSY with bus_ready and bus_error both high the cycle before -> all outputs at reset values, no done.
